// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: owns the register-file write port, zero-sweeps it after reset
// or on clr_start_i, otherwise grants one requester per cycle by round-robin.
module regfile_write_scheduler #(
    parameter int NREQ  = 4,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NREGS = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*AW-1:0]         req_addr_i,
    input  logic [NREQ*DW-1:0]         req_data_i,
    input  logic                       clr_start_i,
    output logic                       rf_we_o,
    output logic [AW-1:0]              rf_waddr_o,
    output logic [DW-1:0]              rf_wdata_o,
    output logic [$clog2(NREQ)-1:0]    grant_id_o,
    output logic                       busy_o,
    output logic                       init_done_o
);
    localparam int IW = $clog2(NREQ);
    localparam logic S_CLEAR = 1'b0;
    localparam logic S_ARB   = 1'b1;

    logic          state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [IW-1:0] gid_q, gid_d;
    logic          init_q, init_d;
    logic [IW-1:0] sel;
    logic          any_valid;
    logic          arb_en;
    logic          go;
    logic          last;

    // Search downward so the lowest offset from rr_ptr_q is the one that sticks.
    always_comb begin
        sel = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[rr_ptr_q + IW'(k)]) begin
                sel = rr_ptr_q + IW'(k);
                any_valid = 1'b1;
            end
        end
    end

    assign arb_en      = (state_q == S_ARB) && !clr_start_i;
    assign go          = arb_en && any_valid;
    assign req_ready_o = go ? (NREQ'(1) << sel) : '0;
    assign last        = clr_cnt_q == AW'(NREGS - 1);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        gid_d     = gid_q;
        init_d    = init_q;
        if (state_q == S_CLEAR) begin
            we_d      = 1'b1;
            waddr_d   = clr_cnt_q;
            wdata_d   = '0;
            clr_cnt_d = last ? '0 : clr_cnt_q + AW'(1);
            state_d   = last ? S_ARB : S_CLEAR;
            init_d    = init_q | last;
        end else if (clr_start_i) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
        end else if (go) begin
            we_d     = 1'b1;
            waddr_d  = req_addr_i[sel*AW +: AW];
            wdata_d  = req_data_i[sel*DW +: DW];
            gid_d    = sel;
            rr_ptr_d = sel + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            gid_q     <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            gid_q     <= gid_d;
            init_q    <= init_d;
        end
    end

    assign rf_we_o     = we_q;
    assign rf_waddr_o  = waddr_q;
    assign rf_wdata_o  = wdata_q;
    assign grant_id_o  = gid_q;
    assign busy_o      = state_q == S_CLEAR;
    assign init_done_o = init_q;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: scoreboard bench; expected writes are queued as stimulus
// is driven and matched against every rf_we_o cycle.
module tb_regfile_write_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [19:0] req_addr;
    logic [127:0] req_data;
    logic        clr_start;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  grant_id;
    logic        busy;
    logic        init_done;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [1:0]  g;
        bit          cg;
    } wr_t;

    wr_t         sb[$];
    logic [4:0]  am[4];
    logic [31:0] dm[4];
    int          checks = 0;
    int          fails = 0;

    regfile_write_scheduler dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .clr_start_i(clr_start),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .grant_id_o(grant_id), .busy_o(busy), .init_done_o(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (sb.size() == 0) chk("unexp_we", 64'(sb.size()), 64'd1);
            else begin
                wr_t e;
                e = sb.pop_front();
                chk("waddr", 64'(rf_waddr), 64'(e.a));
                chk("wdata", 64'(rf_wdata), 64'(e.d));
                if (e.cg) chk("gid", 64'(grant_id), 64'(e.g));
            end
        end
    end

    task automatic push_sweep();
        for (int i = 0; i < 32; i++) sb.push_back('{a: 5'(i), d: 32'd0, g: 2'd0, cg: 1'b0});
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        am[i] = a;
        dm[i] = d;
        req_addr[i*5 +: 5] = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic xfer(input logic [3:0] mask, input int g);
        @(negedge clk);
        req_valid = mask;
        clr_start = 1'b0;
        #1 chk("ready", 64'(req_ready), 64'(4'b0001 << g));
        sb.push_back('{a: am[g], d: dm[g], g: 2'(g), cg: 1'b1});
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1 chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_sweep_done();
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);
        #1 chk("sweep_done", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        clr_start = 1'b0;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
        repeat (2) @(negedge clk);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_init", 64'(init_done), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        req_valid = 4'b1111;
        #1 chk("rst_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        // Test 1: post-reset sweep
        push_sweep();
        rst_n = 1'b1;
        @(negedge clk);
        wait_sweep_done();
        chk("init_set", 64'(init_done), 64'd1);
        @(negedge clk);
        #1 chk("idle_we", 64'(rf_we), 64'd0);
        chk("sweep_drain", 64'(sb.size()), 64'd0);
        // Test 2: single requester, write to addr 5
        set_req(0, 5'd5, 32'd2008040112);
        xfer(4'b0001, 0);
        idle();
        // Bring rr_ptr back to 0 via a lone req3 grant
        xfer(4'b1000, 3);
        idle();
        // Test 3: all valid, addrs 1..4, rotation 0,1,2,3,0
        set_req(0, 5'd1, 32'hB000_0000);
        set_req(1, 5'd2, 32'hB000_0001);
        set_req(2, 5'd3, 32'hB000_0002);
        set_req(3, 5'd4, 32'hB000_0003);
        xfer(4'b1111, 0);
        xfer(4'b1111, 1);
        xfer(4'b1111, 2);
        xfer(4'b1111, 3);
        xfer(4'b1111, 0);
        idle();
        // Test 4: rr_ptr -> 2, then req1/req3 wrap-around
        xfer(4'b0010, 1);
        idle();
        xfer(4'b1010, 3);
        xfer(4'b1010, 1);
        xfer(4'b1010, 3);
        idle();
        // Test 5: clr_start in ARB with req2 pending; address 0 write afterwards
        set_req(2, 5'd0, 32'hC0DE_0002);
        @(negedge clk);
        req_valid = 4'b0100;
        clr_start = 1'b1;
        #1 chk("clr_ready", 64'(req_ready), 64'd0);
        push_sweep();
        @(negedge clk);
        clr_start = 1'b0;
        #1 chk("clr_busy", 64'(busy), 64'd1);
        chk("clr_ready2", 64'(req_ready), 64'd0);
        chk("clr_init", 64'(init_done), 64'd1);
        wait_sweep_done();
        chk("post_ready", 64'(req_ready), 64'd4);
        chk("post_init", 64'(init_done), 64'd1);
        sb.push_back('{a: am[2], d: dm[2], g: 2'd2, cg: 1'b1});
        idle();
        // Test 6: reset at sweep address 17
        @(negedge clk);
        clr_start = 1'b1;
        push_sweep();
        @(negedge clk);
        clr_start = 1'b0;
        for (int n = 0; n < 100 && !(rf_we && rf_waddr == 5'd17); n++) @(negedge clk);
        chk("reach_a17", 64'(rf_waddr), 64'd17);
        #2 rst_n = 1'b0;
        #1 chk("mid_we", 64'(rf_we), 64'd0);
        chk("mid_init", 64'(init_done), 64'd0);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_waddr", 64'(rf_waddr), 64'd0);
        sb.delete();
        push_sweep();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_sweep_done();
        chk("re_init", 64'(init_done), 64'd1);
        chk("re_drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
